// File: rtl/wb_regfile_writer_pkg.sv
// Shared write-back definitions: register file geometry and the register-write record.
// Used by both decode and write-back.
package wb_regfile_writer_pkg;

  localparam int unsigned DATA_W = 19;
  localparam int unsigned NREG   = 8;
  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] R0_IDX = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } reg_wr_t;

  function automatic logic is_r0(input logic [ADDR_W-1:0] idx);
    return idx == R0_IDX;
  endfunction

endpackage

// File: rtl/regfile_8x19.sv
// 8 x 19-bit register file: one write port, two read ports bypassed from the write port.
// R0 is hard-wired to zero.
module regfile_8x19
  import wb_regfile_writer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_rd,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic              wr_live;

  assign wr_live = wr_en && !is_r0(wr_rd);

  // Entry 0 is only ever reset, so it holds zero forever.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_live && wr_rd == ADDR_W'(i)) begin
          regs_q[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
    if (is_r0(rs1_addr)) begin
      rs1_data = '0;
    end else if (wr_live && wr_rd == rs1_addr) begin
      rs1_data = wr_data;
    end
    if (is_r0(rs2_addr)) begin
      rs2_data = '0;
    end else if (wr_live && wr_rd == rs2_addr) begin
      rs2_data = wr_data;
    end
  end

endmodule

// File: rtl/wb_regfile_writer.sv
// Write-back stage: arbitrates load and ALU results onto the register file write port,
// buffers one stalled ALU result, and tracks outstanding writes per register.
module wb_regfile_writer
  import wb_regfile_writer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              commit_valid,
  output logic [ADDR_W-1:0] commit_rd,
  output logic [DATA_W-1:0] commit_data
);

  reg_wr_t         hold_q, hold_d;
  logic            hold_valid_q, hold_valid_d;
  logic            alu_xfer;
  reg_wr_t         wr;
  logic            wr_sel;
  logic            wr_en;
  logic [NREG-1:0] busy_q, busy_d;
  logic            commit_valid_q;
  reg_wr_t         commit_q;

  assign alu_ready = !hold_valid_q;
  assign alu_xfer  = alu_valid && alu_ready;

  // Priority: load (cannot stall) > held ALU entry > fresh ALU result.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    wr_sel       = 1'b0;
    wr           = '0;
    if (mem_valid) begin
      wr_sel = 1'b1;
      wr     = '{rd: mem_rd, data: mem_data};
      if (alu_xfer) begin
        hold_valid_d = 1'b1;
        hold_d       = '{rd: alu_rd, data: alu_data};
      end
    end else if (hold_valid_q) begin
      wr_sel       = 1'b1;
      wr           = hold_q;
      hold_valid_d = 1'b0;
    end else if (alu_xfer) begin
      wr_sel = 1'b1;
      wr     = '{rd: alu_rd, data: alu_data};
    end
  end

  // Writes to R0 are dropped entirely: no commit and no scoreboard effect.
  assign wr_en = wr_sel && !is_r0(wr.rd);

  // A newer issue to the same register outranks the completing write.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr.rd] = 1'b0;
    end
    if (issue_valid && !is_r0(issue_rd)) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid_q   <= 1'b0;
      hold_q         <= '0;
      busy_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_q       <= '0;
    end else begin
      hold_valid_q   <= hold_valid_d;
      hold_q         <= hold_d;
      busy_q         <= busy_d;
      commit_valid_q <= wr_en;
      if (wr_en) begin
        commit_q <= wr;
      end
    end
  end

  assign rs1_busy = busy_q[rs1_addr] && !(wr_en && wr.rd == rs1_addr);
  assign rs2_busy = busy_q[rs2_addr] && !(wr_en && wr.rd == rs2_addr);

  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_q.rd;
  assign commit_data  = commit_q.data;

  regfile_8x19 u_regfile (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_rd    (wr.rd),
    .wr_data  (wr.data),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Bench for wb_regfile_writer: directed scenarios plus random traffic against a
// queue-based reference model of the write-back stage.
module tb_wb_regfile_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, alu_ready;
  logic [2:0]  alu_rd, mem_rd, issue_rd, rs1_addr, rs2_addr, commit_rd;
  logic [18:0] alu_data, mem_data, rs1_data, rs2_data, commit_data;
  logic        mem_valid, issue_valid, rs1_busy, rs2_busy, commit_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [18:0] m_regs [8];
  bit          m_busy [8];
  int          hq_rd[$];
  int          hq_data[$];
  bit          m_cv;
  int          m_crd, m_cdata;
  bit          last_stall;

  always #5 clk = ~clk;

  wb_regfile_writer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    hq_rd.delete();
    hq_data.delete();
    m_cv = 1'b0;
    m_crd = 0;
    m_cdata = 0;
    last_stall = 1'b0;
  endtask

  // Called after inputs are driven, away from the clock edge; returns at the next posedge.
  task automatic step();
    int  c_rd[$];
    int  c_data[$];
    bit  exp_ready, xfer, eff;
    int  srd, sdata;
    logic [18:0] e1, e2;
    bit  b1, b2;
    #1;
    exp_ready = (hq_rd.size() == 0);
    xfer = alu_valid && exp_ready;
    if (mem_valid) begin
      c_rd.push_back(int'(mem_rd));
      c_data.push_back(int'(mem_data));
    end
    foreach (hq_rd[i]) begin
      c_rd.push_back(hq_rd[i]);
      c_data.push_back(hq_data[i]);
    end
    if (xfer) begin
      c_rd.push_back(int'(alu_rd));
      c_data.push_back(int'(alu_data));
    end
    eff = 1'b0;
    srd = 0;
    sdata = 0;
    if (c_rd.size() > 0) begin
      srd = c_rd.pop_front();
      sdata = c_data.pop_front();
      eff = (srd != 0);
    end
    e1 = (rs1_addr == 0) ? 19'd0 : (eff && srd == int'(rs1_addr)) ? 19'(sdata) : m_regs[rs1_addr];
    e2 = (rs2_addr == 0) ? 19'd0 : (eff && srd == int'(rs2_addr)) ? 19'(sdata) : m_regs[rs2_addr];
    b1 = m_busy[rs1_addr] && !(eff && srd == int'(rs1_addr));
    b2 = m_busy[rs2_addr] && !(eff && srd == int'(rs2_addr));
    check_eq("alu_ready", 32'(alu_ready), 32'(exp_ready));
    check_eq("rs1_data", 32'(rs1_data), 32'(e1));
    check_eq("rs2_data", 32'(rs2_data), 32'(e2));
    check_eq("rs1_busy", 32'(rs1_busy), 32'(b1));
    check_eq("rs2_busy", 32'(rs2_busy), 32'(b2));
    check_eq("commit_valid", 32'(commit_valid), 32'(m_cv));
    if (m_cv) begin
      check_eq("commit_rd", 32'(commit_rd), 32'(m_crd));
      check_eq("commit_data", 32'(commit_data), 32'(m_cdata));
    end
    last_stall = alu_valid && !exp_ready;
    hq_rd = c_rd;
    hq_data = c_data;
    if (eff) begin
      m_regs[srd] = 19'(sdata);
      m_busy[srd] = 1'b0;
    end
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    m_cv = eff;
    if (eff) begin
      m_crd = srd;
      m_cdata = sdata;
    end
    @(posedge clk);
  endtask

  task automatic drive(input bit mv, input int mrd, input int mdata,
                       input bit av, input int ard, input int adata,
                       input bit iv, input int ird, input int r1, input int r2);
    @(negedge clk);
    mem_valid = mv;  mem_rd = 3'(mrd);  mem_data = 19'(mdata);
    alu_valid = av;  alu_rd = 3'(ard);  alu_data = 19'(adata);
    issue_valid = iv; issue_rd = 3'(ird);
    rs1_addr = 3'(r1); rs2_addr = 3'(r2);
    step();
  endtask

  task automatic idle(input int r1, input int r2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  initial begin
    reset_n = 1'b0;
    {alu_valid, mem_valid, issue_valid} = '0;
    {alu_rd, mem_rd, issue_rd} = '0;
    alu_data = '0; mem_data = '0;
    rs1_addr = 3'd3; rs2_addr = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_commit_rd", 32'(commit_rd), 32'd0);
    check_eq("reset_commit_data", 32'(commit_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: reset state through the read ports
    idle(3, 0);
    // 2: issue, then ALU write bypassed the same cycle
    drive(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
    drive(0, 0, 0, 1, 5, 'h1ABCD, 0, 0, 5, 5);
    idle(5, 0);
    // 3: mem and ALU together; ALU held one cycle
    drive(1, 2, 'h00011, 1, 4, 'h7FFFF, 1, 4, 4, 2);
    idle(4, 2);
    idle(4, 2);
    // 4: held ALU entry starved by three consecutive loads
    drive(1, 6, 'h11111, 1, 1, 'h0F0F0, 1, 1, 1, 6);
    drive(1, 6, 'h22222, 1, 1, 'h0F0F0, 0, 0, 1, 6);
    drive(1, 6, 'h33333, 1, 1, 'h0F0F0, 0, 0, 1, 6);
    idle(1, 6);
    idle(1, 6);
    // 5: same-rd collision; younger ALU value must win
    drive(1, 3, 'h00AAA, 1, 3, 'h00555, 0, 0, 3, 0);
    idle(3, 0);
    idle(3, 0);
    check_eq("collision_r3", 32'(rs1_data), 32'h00555);
    // 6: R0 write dropped; set-wins on issue/write to same rd
    drive(0, 0, 0, 1, 0, 'h12345, 1, 0, 0, 0);
    idle(0, 0);
    drive(0, 0, 0, 1, 7, 'h00777, 1, 7, 7, 0);
    idle(7, 0);
    // Reset while an ALU entry is held
    drive(1, 2, 'h00042, 1, 5, 'h00055, 1, 6, 6, 5);
    @(negedge clk);
    reset_n = 1'b0;
    mem_valid = 1'b0; alu_valid = 1'b0; issue_valid = 1'b0;
    #1;
    check_eq("rst_alu_ready", 32'(alu_ready), 32'd1);
    check_eq("rst_commit_valid", 32'(commit_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rs1_addr = 3'(i);
      rs2_addr = 3'(7 - i);
      #1;
      check_eq("rst_busy1", 32'(rs1_busy), 32'd0);
      check_eq("rst_busy2", 32'(rs2_busy), 32'd0);
      check_eq("rst_data1", 32'(rs1_data), 32'd0);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(5, 6);

    // Random traffic; a stalled ALU offer stays stable until accepted
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      mem_valid = ($urandom_range(0, 99) < 40);
      mem_rd = 3'($urandom_range(0, 7));
      mem_data = 19'($urandom);
      if (!last_stall) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_rd = 3'($urandom_range(0, 7));
        alu_data = 19'($urandom);
      end
      issue_valid = ($urandom_range(0, 99) < 50);
      issue_rd = 3'($urandom_range(0, 7));
      rs1_addr = 3'($urandom_range(0, 7));
      rs2_addr = 3'($urandom_range(0, 7));
      step();
    end

    // Drain and read back every register
    for (int i = 0; i < 8; i++) idle(i, 7 - i);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile_writer.md
Name: wb_regfile_writer

Overview:
- Write-back end of the 19-bit pipeline: owns the 8 x 19-bit register file that the decode stage reads.
- Accepts results from two producers: the ALU path (ready/valid) and the memory/load path (valid only, never stalled).
- Arbitrates them onto the single write port, provides two bypassed combinational read ports to decode, and keeps a pending-write scoreboard.

Parameters:
- DATA_W, 19, register and result width
- NREG, 8, number of architectural registers
- ADDR_W, 3, register index width (log2 NREG)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result can be accepted this cycle
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result present; must be accepted this cycle
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load result
- issue_valid  in  1  decode issued an instruction that will write issue_rd
- issue_rd  in  ADDR_W  destination of issued instruction
- rs1_addr  in  ADDR_W  decode read port 1 index
- rs2_addr  in  ADDR_W  decode read port 2 index
- rs1_data  out  DATA_W  read port 1 data, combinational
- rs2_data  out  DATA_W  read port 2 data, combinational
- rs1_busy  out  1  rs1 has an outstanding write not yet available
- rs2_busy  out  1  rs2 has an outstanding write not yet available
- commit_valid  out  1  registered: a register was written last cycle
- commit_rd  out  ADDR_W  register written last cycle
- commit_data  out  DATA_W  value written last cycle

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - all registers 0, busy[7:0]=0, hold buffer empty
  - commit_valid=0, commit_rd=0, commit_data=0
  - alu_ready=1 (comb. from empty hold buffer)
- R0 is constant zero:
  - writes with rd=0 are dropped: no commit, no scoreboard change
  - reads of index 0 return 0
  - busy[0] is never set
- Hold buffer: one entry {rd,data}, hold_valid. alu_ready = !hold_valid. ALU transfer occurs when alu_valid && alu_ready.
- One write per cycle. Write source priority:
  1. mem_valid
  2. held ALU entry
  3. newly transferred ALU result
- Per-cycle cases:
  - mem_valid, no ALU transfer: write mem. A held entry stays held.
  - mem_valid and ALU transfer: write mem; ALU result goes into the hold buffer. It was empty, since alu_ready=1.
  - no mem, hold_valid: write the held entry; hold empties at the clock edge; alu_ready returns 1 the next cycle.
  - no mem, no hold, ALU transfer: write the ALU result directly, zero added latency.
- Same-rd collision between mem and ALU: mem writes first and the ALU (younger) value overwrites later. The final register value is the ALU data.
- Write timing:
  - write occurs at the rising edge ending the cycle in which it is selected
  - commit_* shows it in the following cycle for one cycle
  - commit_valid=0 in cycles with no write
- Read ports:
  - combinational from array
  - bypass: if a write to the same nonzero index is selected in the current cycle, return that write's data
- Scoreboard:
  - issue_valid with issue_rd!=0 sets busy[issue_rd] at the edge
  - a selected write to rd clears busy[rd] at the edge
  - simultaneous set and clear of the same rd: set wins, since a newer producer is outstanding
- Busy outputs: rsN_busy = busy[rsN_addr] && !(write to rsN_addr selected this cycle). The bypass already supplies the data.
- A held ALU entry is not visible via bypass until it is selected. Its rd remains busy.
- Reset mid-operation: the hold content is discarded and the scoreboard is cleared. Producers must treat in-flight results as lost.
- Widths: no arithmetic; all data paths are exactly DATA_W; indices are ADDR_W with no wrap concerns.

Decomposition:
- Shared package: DATA_W, ADDR_W, NREG, the R0 index constant, and the register-write record type {rd, data}. The decode stage and this block both use these.
- One sub-module: regfile_8x19. It contains the storage array, write port, R0 masking and two bypassed read ports.
- The arbiter, hold buffer, scoreboard and commit register stay in wb_regfile_writer.

Test Plan:
1. Reset, then read rs1=3, rs2=0 -> both data 0, both busy 0, alu_ready=1, commit_valid=0.
2. issue rd=5; next cycle ALU rd=5 data=0x1ABCD with no mem -> rs1_addr=5 returns 0x1ABCD same cycle via bypass with busy=0. Next cycle commit {5,0x1ABCD}, busy[5]=0.
3. Same cycle mem rd=2 data=0x00011 and ALU rd=4 data=0x7FFFF -> mem commits first. ALU is held and alu_ready=0 for one cycle; rd=4 is written in cycle+1 and commit shows rd=4 in cycle+2.
4. mem on rd=6 for 3 consecutive cycles while ALU rd=1 is held -> hold persists and alu_ready stays 0 throughout. The held value writes on the first mem-free cycle.
5. Collision: mem rd=3 data=0x00AAA and ALU rd=3 data=0x00555 in the same cycle -> final R3=0x00555, two commits in order AAA then 555.
6. Write rd=0 data=0x12345 -> no commit, R0 reads 0. Then issue rd=7 and a write to rd=7 in the same cycle -> busy[7] stays 1. Assert reset_n=0 mid-hold -> hold cleared, alu_ready=1, all busy=0.
